slp_train_seq: RTL
==================

// Module: slp_train_seq
// PURPOSE
//  Training sequencer that drives the training port of a single-layer perceptron.
//  It buffers up to DEPTH labelled samples, then replays them for successive epochs.
//  For each sample it presents in/train/rate, checks the perceptron's inference, and pulses t_en.
//  It stops on the first error-free epoch or when max_epoch is reached; it sits between the sample source and the perceptron.
// PARAMETERS
//  IN       8   inputs per sample (matches perceptron IN)
//  I_PREC  16   input element width
//  O_PREC  16   label / inference width
//  R_PREC  16   learning-rate width
//  DEPTH   16   sample buffer entries (power of 2)
//  EPOCH_W  8   epoch counter width
// PORTS
//  clk        in   1              clock, all logic rising-edge
//  reset      in   1              synchronous, active-high
//  ld_valid   in   1              sample load request
//  ld_ready   out  1              buffer accepts a sample
//  ld_in      in   IN*I_PREC      sample inputs
//  ld_train   in   O_PREC         sample label
//  clear      in   1              empty the buffer (IDLE only)
//  start      in   1              begin training (IDLE only)
//  max_epoch  in   EPOCH_W        epoch limit, sampled at start
//  rate_init  in   R_PREC         initial learning rate, sampled at start
//  decay_en   in   1              halve the rate per epoch, sampled at start
//  slp_in     out  IN*I_PREC      to perceptron in
//  slp_train  out  O_PREC         to perceptron train
//  slp_rate   out  R_PREC         to perceptron rate
//  slp_t_en   out  1              to perceptron t_en
//  slp_out    in   O_PREC         perceptron inference (combinational from slp_in)
//  busy       out  1              training in progress
//  done       out  1              level; set at end, cleared by next accepted start or by clear
//  converged  out  1              valid while done=1; last epoch had zero errors
//  epoch_cnt  out  EPOCH_W        epochs completed
//  err_cnt    out  $clog2(DEPTH)+1  mismatches in the current/last epoch
// BEHAVIOUR
//  Reset: all registered outputs and counters are 0, state=IDLE, buffer count=0; ld_ready=1 combinationally.
//  ld_ready = (state==IDLE) && (count<DEPTH).
//  Load: a sample is written at entry count when ld_valid&&ld_ready; count increments.
//  clear in IDLE: count=0, done=0, converged=0. clear outside IDLE is ignored.
//  Precedence in IDLE: clear wins over start and load in the same cycle; start wins over load (load not accepted).
//  States: IDLE, FETCH, EVAL, UPD, CHECK.
//  IDLE --start--> FETCH.
//    If count==0, go instead to IDLE with done=1, converged=0, epoch_cnt=0.
//    On start: idx=0, err=0, epoch_cnt=0, slp_rate=rate_init, done=0; a max_epoch of 0 acts as 1.
//  FETCH: register buf[idx] into slp_in/slp_train; next state EVAL.
//  EVAL: slp_t_en=0; if slp_out!=slp_train (exact O_PREC compare), err_cnt++; next state UPD.
//  UPD: slp_t_en=1 for exactly this cycle, so the weights update at the closing edge.
//    If idx==count-1, go to CHECK; else idx++ and go to FETCH.
//  Each sample takes 3 cycles; slp_t_en is 0 in every other state.
//  CHECK: epoch_cnt++.
//    If err_cnt==0: done=1, converged=1, go to IDLE.
//    Else if epoch_cnt+1 >= limit: done=1, converged=0, go to IDLE.
//    Else: idx=0, err_cnt=0, go to FETCH.
//    When continuing with decay_en=1, slp_rate = slp_rate>>1, floored at 1 (a rate of 0 stays 0).
//  err_cnt holds its final value in IDLE.
//  busy=1 in every state except IDLE.
//  slp_in, slp_train and slp_rate hold their last values in IDLE.
//  start while busy is ignored.
//  Reset mid-training aborts immediately to the reset values; the buffer count is lost.
// TESTING
//  Reset: after reset, ld_ready=1, busy=0, done=0, slp_t_en=0, epoch_cnt=0.
//  Load/full: push 16 samples -> ld_ready drops after the 16th. Hold ld_valid for a 17th -> count stays 16 and the sample is not written.
//  Converge: 4 samples, stub slp_out==slp_train, start with max_epoch=5 ->
//    12 cycles of FETCH/EVAL/UPD, t_en pulses 4 times, then done=1, converged=1, epoch_cnt=1, err_cnt=0.
//  Limit/decay: stub always mismatching, 2 samples, max_epoch=3, rate_init=8, decay_en=1 ->
//    slp_rate is 8,4,2 across epochs, done with converged=0, epoch_cnt=3, err_cnt=2.
//  Empty start: start with count=0 -> the next cycle shows done=1, converged=0, busy=0, and no t_en.
//  Abort: assert reset during the second epoch's EVAL -> next cycle all outputs are 0, ld_ready=1, and a new load/start works.

Source files
------------

// File: rtl/slp_train_seq.sv
// Training sequencer for a single-layer perceptron: buffers labelled samples and
// replays them epoch by epoch, pulsing t_en once per sample until convergence or the epoch limit.
module slp_train_seq #(
  parameter int IN      = 8,
  parameter int I_PREC  = 16,
  parameter int O_PREC  = 16,
  parameter int R_PREC  = 16,
  parameter int DEPTH   = 16,
  parameter int EPOCH_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [IN*I_PREC-1:0]          ld_in,
  input  logic [O_PREC-1:0]             ld_train,
  input  logic                          clear,
  input  logic                          start,
  input  logic [EPOCH_W-1:0]            max_epoch,
  input  logic [R_PREC-1:0]             rate_init,
  input  logic                          decay_en,
  output logic [IN*I_PREC-1:0]          slp_in,
  output logic [O_PREC-1:0]             slp_train,
  output logic [R_PREC-1:0]             slp_rate,
  output logic                          slp_t_en,
  input  logic [O_PREC-1:0]             slp_out,
  output logic                          busy,
  output logic                          done,
  output logic                          converged,
  output logic [EPOCH_W-1:0]            epoch_cnt,
  output logic [$clog2(DEPTH):0]        err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] EVAL  = 3'd2;
  localparam logic [2:0] UPD   = 3'd3;
  localparam logic [2:0] CHECK = 3'd4;

  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]      CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0]      IDX_ONE  = AW'(1);
  localparam logic [EPOCH_W-1:0] EP_ONE   = EPOCH_W'(1);
  localparam logic [EPOCH_W:0]   EPX_ONE  = (EPOCH_W+1)'(1);
  localparam logic [R_PREC-1:0]  RATE_ONE = R_PREC'(1);

  logic [IN*I_PREC-1:0] inMem    [DEPTH];
  logic [O_PREC-1:0]    trainMem [DEPTH];

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        err_q, err_d;
  logic [EPOCH_W-1:0]   epoch_q, epoch_d;
  logic [EPOCH_W-1:0]   limit_q, limit_d;
  logic                 decay_q, decay_d;
  logic [R_PREC-1:0]    rate_q, rate_d;
  logic [IN*I_PREC-1:0] in_q, in_d;
  logic [O_PREC-1:0]    train_q, train_d;
  logic                 done_q, done_d;
  logic                 conv_q, conv_d;
  logic                 loadAccept;

  assign ld_ready   = (state_q == IDLE) && (count_q < CNT_FULL);
  assign loadAccept = ld_valid && ld_ready && !clear && !start;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    err_d   = err_q;
    epoch_d = epoch_q;
    limit_d = limit_q;
    decay_d = decay_q;
    rate_d  = rate_q;
    in_d    = in_q;
    train_d = train_q;
    done_d  = done_q;
    conv_d  = conv_q;
    case (state_q)
      IDLE: begin
        // clear beats start, and start beats a load in the same cycle
        if (clear) begin
          count_d = '0;
          done_d  = 1'b0;
          conv_d  = 1'b0;
        end else if (start) begin
          idx_d   = '0;
          err_d   = '0;
          epoch_d = '0;
          rate_d  = rate_init;
          limit_d = (max_epoch == '0) ? EP_ONE : max_epoch;
          decay_d = decay_en;
          conv_d  = 1'b0;
          done_d  = (count_q == '0);
          state_d = (count_q == '0) ? IDLE : FETCH;
        end else if (loadAccept) begin
          count_d = count_q + CNT_ONE;
        end
      end
      FETCH: begin
        in_d    = inMem[idx_q];
        train_d = trainMem[idx_q];
        state_d = EVAL;
      end
      EVAL: begin
        if (slp_out != train_q) err_d = err_q + CNT_ONE;
        state_d = UPD;
      end
      UPD: begin
        if ({1'b0, idx_q} == count_q - CNT_ONE) begin
          state_d = CHECK;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = FETCH;
        end
      end
      CHECK: begin
        epoch_d = epoch_q + EP_ONE;
        if (err_q == '0) begin
          done_d  = 1'b1;
          conv_d  = 1'b1;
          state_d = IDLE;
        end else if (({1'b0, epoch_q} + EPX_ONE) >= {1'b0, limit_q}) begin
          done_d  = 1'b1;
          conv_d  = 1'b0;
          state_d = IDLE;
        end else begin
          idx_d   = '0;
          err_d   = '0;
          state_d = FETCH;
          // halving floors at 1 so a nonzero rate never decays to zero
          if (decay_q) rate_d = (rate_q > RATE_ONE) ? (rate_q >> 1) : rate_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      epoch_q <= '0;
      limit_q <= '0;
      decay_q <= 1'b0;
      rate_q  <= '0;
      in_q    <= '0;
      train_q <= '0;
      done_q  <= 1'b0;
      conv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      epoch_q <= epoch_d;
      limit_q <= limit_d;
      decay_q <= decay_d;
      rate_q  <= rate_d;
      in_q    <= in_d;
      train_q <= train_d;
      done_q  <= done_d;
      conv_q  <= conv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (loadAccept) begin
      inMem[count_q[AW-1:0]]    <= ld_in;
      trainMem[count_q[AW-1:0]] <= ld_train;
    end
  end

  assign slp_in    = in_q;
  assign slp_train = train_q;
  assign slp_rate  = rate_q;
  assign slp_t_en  = (state_q == UPD);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign converged = conv_q;
  assign epoch_cnt = epoch_q;
  assign err_cnt   = err_q;

endmodule
